// File: rtl/se_sram_arbiter_2port.sv
// se_sram_arbiter_2port
//
// Lets two requesters, A and B, share one single-port synchronous SRAM. The SRAM
// takes one access per cycle and returns read data one cycle later from a register.
//
// Arbitration is round-robin. A requester can also lock ownership for a burst. A lock
// lasts for at most LOCK_MAX_GRANTS consecutive grants. Read data is steered back to
// whichever requester issued the read, one cycle after its grant.
//
// Ports
//   sram_clock            single clock; all state changes on its rising edge
//   reset_n               asynchronous, active-low reset
//   a_req / b_req         access request, held by the requester until acked
//   a_/b_read_not_write   1 = read, 0 = write
//   a_lock / b_lock       keep ownership after this grant (burst)
//   a_/b_address          access address
//   a_/b_write_data       write data
//   a_ack / b_ack         request accepted this cycle
//   a_/b_read_valid       read data valid this cycle
//   a_/b_read_data        read data, meaningful only while read_valid is high
//   sram_select, sram_read_not_write, sram_write_enable,
//   sram_address, sram_write_data     drive the SRAM
//   sram_data_out         registered read data from the SRAM

module se_sram_arbiter_2port #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int LOCK_MAX_GRANTS = 16
) (
    input  logic                  sram_clock,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_read_not_write,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_write_data,
    input  logic                  b_req,
    input  logic                  b_read_not_write,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_write_data,
    output logic                  a_ack,
    output logic                  a_read_valid,
    output logic [DATA_WIDTH-1:0] a_read_data,
    output logic                  b_ack,
    output logic                  b_read_valid,
    output logic [DATA_WIDTH-1:0] b_read_data,
    output logic                  sram_select,
    output logic                  sram_read_not_write,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_data_out
);

    localparam int CW = $clog2(LOCK_MAX_GRANTS + 1);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(LOCK_MAX_GRANTS);

    // last_grant encoding: 0 = A, 1 = B
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} lock_state_t;

    lock_state_t   state, state_next;
    logic          last_grant, last_grant_next;
    logic [CW-1:0] lock_count, lock_count_next;
    logic [CW-1:0] count_inc;
    logic          grant_a, grant_b;

    // Grant decision. The reset_n gating keeps acks and the SRAM select low for as
    // long as reset is held, even when requests are already present.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    grant_a = (last_grant == LAST_B);
                    grant_b = (last_grant == LAST_A);
                end else begin
                    grant_a = a_req;
                    grant_b = b_req;
                end
            end
            OWN_A:   grant_a = a_req;
            OWN_B:   grant_b = b_req;
            default: ;
        endcase
        grant_a = grant_a & reset_n;
        grant_b = grant_b & reset_n;
    end

    // State register: lock FSM, round-robin pointer, burst counter and read-return flags
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= LAST_B;
            lock_count   <= '0;
            a_read_valid <= 1'b0;
            b_read_valid <= 1'b0;
        end else begin
            state        <= state_next;
            last_grant   <= last_grant_next;
            lock_count   <= lock_count_next;
            a_read_valid <= grant_a & a_read_not_write;
            b_read_valid <= grant_b & b_read_not_write;
        end
    end

    assign count_inc = lock_count + COUNT_ONE;

    // Next-state logic for the lock FSM.
    // Every release path from OWN_x leaves last_grant pointing at x. That lets a
    // requester that was waiting win the very next cycle.
    always_comb begin
        state_next      = state;
        lock_count_next = lock_count;
        last_grant_next = last_grant;
        if (grant_a) last_grant_next = LAST_A;
        if (grant_b) last_grant_next = LAST_B;
        case (state)
            IDLE: begin
                if (grant_a && a_lock) begin
                    lock_count_next = COUNT_ONE;
                    state_next      = (COUNT_ONE == COUNT_MAX) ? IDLE : OWN_A;
                end else if (grant_b && b_lock) begin
                    lock_count_next = COUNT_ONE;
                    state_next      = (COUNT_ONE == COUNT_MAX) ? IDLE : OWN_B;
                end
            end
            OWN_A: begin
                if (!a_req) begin
                    state_next = IDLE;
                end else if (a_lock) begin
                    lock_count_next = count_inc;
                    if (count_inc == COUNT_MAX) state_next = IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            OWN_B: begin
                if (!b_req) begin
                    state_next = IDLE;
                end else if (b_lock) begin
                    lock_count_next = count_inc;
                    if (count_inc == COUNT_MAX) state_next = IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: acks and SRAM drive. With no grant the SRAM sees an idle read of 0.
    always_comb begin
        a_ack               = grant_a;
        b_ack               = grant_b;
        sram_select         = 1'b0;
        sram_read_not_write = 1'b1;
        sram_write_enable   = 1'b0;
        sram_address        = '0;
        sram_write_data     = '0;
        if (grant_a) begin
            sram_select         = 1'b1;
            sram_read_not_write = a_read_not_write;
            sram_write_enable   = !a_read_not_write;
            sram_address        = a_address;
            sram_write_data     = a_write_data;
        end else if (grant_b) begin
            sram_select         = 1'b1;
            sram_read_not_write = b_read_not_write;
            sram_write_enable   = !b_read_not_write;
            sram_address        = b_address;
            sram_write_data     = b_write_data;
        end
    end

    // Read data comes straight from the SRAM output register. The read_valid flags
    // decide which requester it belongs to.
    assign a_read_data = sram_data_out;
    assign b_read_data = sram_data_out;

endmodule

// File: tb/tb_se_sram_arbiter_2port.sv
// tb_se_sram_arbiter_2port
//
// Directed bench for se_sram_arbiter_2port. A behavioural single-port SRAM with
// registered read data sits behind the main instance (LOCK_MAX_GRANTS=16).
// A second instance with LOCK_MAX_GRANTS=1 receives the same requests, so the
// degenerate lock length can be observed side by side with the main instance.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// well clear of the rising edge.

module tb_se_sram_arbiter_2port;

    logic        sram_clock;
    logic        reset_n;
    logic        a_req, a_read_not_write, a_lock;
    logic [15:0] a_address;
    logic [7:0]  a_write_data;
    logic        b_req, b_read_not_write, b_lock;
    logic [15:0] b_address;
    logic [7:0]  b_write_data;
    logic        a_ack, a_read_valid, b_ack, b_read_valid;
    logic [7:0]  a_read_data, b_read_data;
    logic        sram_select, sram_read_not_write, sram_write_enable;
    logic [15:0] sram_address;
    logic [7:0]  sram_write_data;
    logic [7:0]  sram_data_out;

    logic        one_a_ack, one_b_ack, one_a_read_valid, one_b_read_valid;
    logic [7:0]  one_a_read_data, one_b_read_data;
    logic        one_select, one_read_not_write, one_write_enable;
    logic [15:0] one_address;
    logic [7:0]  one_write_data;

    logic [7:0]  mem [0:65535];

    int error_count = 0;
    int check_count = 0;

    se_sram_arbiter_2port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LOCK_MAX_GRANTS(16)) dut (
        .sram_clock(sram_clock), .reset_n(reset_n),
        .a_req(a_req), .a_read_not_write(a_read_not_write), .a_lock(a_lock),
        .a_address(a_address), .a_write_data(a_write_data),
        .b_req(b_req), .b_read_not_write(b_read_not_write), .b_lock(b_lock),
        .b_address(b_address), .b_write_data(b_write_data),
        .a_ack(a_ack), .a_read_valid(a_read_valid), .a_read_data(a_read_data),
        .b_ack(b_ack), .b_read_valid(b_read_valid), .b_read_data(b_read_data),
        .sram_select(sram_select), .sram_read_not_write(sram_read_not_write),
        .sram_write_enable(sram_write_enable), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_data_out(sram_data_out)
    );

    se_sram_arbiter_2port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LOCK_MAX_GRANTS(1)) dut_one (
        .sram_clock(sram_clock), .reset_n(reset_n),
        .a_req(a_req), .a_read_not_write(a_read_not_write), .a_lock(a_lock),
        .a_address(a_address), .a_write_data(a_write_data),
        .b_req(b_req), .b_read_not_write(b_read_not_write), .b_lock(b_lock),
        .b_address(b_address), .b_write_data(b_write_data),
        .a_ack(one_a_ack), .a_read_valid(one_a_read_valid), .a_read_data(one_a_read_data),
        .b_ack(one_b_ack), .b_read_valid(one_b_read_valid), .b_read_data(one_b_read_data),
        .sram_select(one_select), .sram_read_not_write(one_read_not_write),
        .sram_write_enable(one_write_enable), .sram_address(one_address),
        .sram_write_data(one_write_data), .sram_data_out(sram_data_out)
    );

    initial sram_clock = 1'b0;
    always #5 sram_clock = ~sram_clock;

    // Behavioural SRAM: registered read, write on select. Location 0x0010 is
    // preloaded with 0x5A whenever reset is held across a rising edge.
    always @(posedge sram_clock) begin
        if (!reset_n) begin
            mem[16'h0010] <= 8'h5A;
        end else if (sram_select) begin
            if (sram_write_enable) mem[sram_address] <= sram_write_data;
            else                   sram_data_out     <= mem[sram_address];
        end
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive both requesters for one cycle and leave the caller at the sampling point
    task automatic applyStimulus(
        input logic ar, input logic arw, input logic al, input logic [15:0] aa, input logic [7:0] awd,
        input logic br, input logic brw, input logic bl, input logic [15:0] ba, input logic [7:0] bwd);
        @(negedge sram_clock);
        a_req = ar; a_read_not_write = arw; a_lock = al; a_address = aa; a_write_data = awd;
        b_req = br; b_read_not_write = brw; b_lock = bl; b_address = ba; b_write_data = bwd;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    endtask

    initial begin
        sram_data_out = 8'h00;
        reset_n = 1'b0;
        a_req = 1'b1; a_read_not_write = 1'b1; a_lock = 1'b0; a_address = 16'h0010; a_write_data = 8'h0;
        b_req = 1'b1; b_read_not_write = 1'b1; b_lock = 1'b0; b_address = 16'h0;    b_write_data = 8'h0;

        // Reset held with requests present: everything must stay quiet
        @(negedge sram_clock);
        @(negedge sram_clock);
        #1;
        checkOutput("rst_a_ack", a_ack, 0);
        checkOutput("rst_b_ack", b_ack, 0);
        checkOutput("rst_select", sram_select, 0);
        checkOutput("rst_we", sram_write_enable, 0);
        checkOutput("rst_a_rv", a_read_valid, 0);
        checkOutput("rst_b_rv", b_read_valid, 0);

        idleCycle();
        reset_n = 1'b1;

        // Test 1: single A read of 0x0010
        $display("[TB] single read");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        checkOutput("t1_a_ack", a_ack, 1);
        checkOutput("t1_b_ack", b_ack, 0);
        checkOutput("t1_select", sram_select, 1);
        checkOutput("t1_rnw", sram_read_not_write, 1);
        checkOutput("t1_we", sram_write_enable, 0);
        checkOutput("t1_addr", sram_address, 16'h0010);
        checkOutput("t1_a_rv_early", a_read_valid, 0);
        idleCycle();
        checkOutput("t1_a_rv", a_read_valid, 1);
        checkOutput("t1_a_rd", a_read_data, 8'h5A);
        checkOutput("t1_b_rv", b_read_valid, 0);
        checkOutput("t1_idle_ack", a_ack, 0);
        checkOutput("t1_idle_select", sram_select, 0);
        checkOutput("t1_idle_rnw", sram_read_not_write, 1);
        checkOutput("t1_idle_addr", sram_address, 16'h0);
        idleCycle();
        checkOutput("t1_a_rv_drop", a_read_valid, 0);

        // Test 2: both requesting, no lock; last grant was A so B goes first
        $display("[TB] alternating grants");
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
            exp_b = (i % 2 == 0);
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0020, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h0);
            checkOutput($sformatf("t2_b_ack%0d", i), b_ack, exp_b);
            checkOutput($sformatf("t2_a_ack%0d", i), a_ack, !exp_b);
            checkOutput($sformatf("t2_addr%0d", i), sram_address, exp_b ? 16'h0030 : 16'h0020);
            if (i > 0) begin
                checkOutput($sformatf("t2_b_rv%0d", i), b_read_valid, !exp_b);
                checkOutput($sformatf("t2_a_rv%0d", i), a_read_valid, exp_b);
            end
        end

        // Test 3: A writes 0x12 to 0x0100, then B reads it back
        $display("[TB] write then read");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0100, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        checkOutput("t3_a_ack", a_ack, 1);
        checkOutput("t3_we", sram_write_enable, 1);
        checkOutput("t3_rnw", sram_read_not_write, 0);
        checkOutput("t3_addr", sram_address, 16'h0100);
        checkOutput("t3_wdata", sram_write_data, 8'h12);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0100, 8'h0);
        checkOutput("t3_b_ack", b_ack, 1);
        checkOutput("t3_b_we", sram_write_enable, 0);
        checkOutput("t3_write_no_rv", a_read_valid, 0);
        idleCycle();
        checkOutput("t3_b_rv", b_read_valid, 1);
        checkOutput("t3_b_rd", b_read_data, 8'h12);
        checkOutput("t3_a_rv", a_read_valid, 0);

        // Test 4: A locked for 20 reads with B waiting throughout.
        // Main instance: A for 16 grants, B once, then A again.
        // Single-grant instance: the lock never holds, so A and B alternate.
        $display("[TB] lock limit");
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h0);
            checkOutput($sformatf("t4_a_ack%0d", i), a_ack, i != 17);
            checkOutput($sformatf("t4_b_ack%0d", i), b_ack, i == 17);
            checkOutput($sformatf("t4_one_a_ack%0d", i), one_a_ack, i % 2 == 1);
            checkOutput($sformatf("t4_one_b_ack%0d", i), one_b_ack, i % 2 == 0);
        end
        idleCycle();
        checkOutput("t4_release_select", sram_select, 0);
        checkOutput("t4_release_we", sram_write_enable, 0);
        checkOutput("t4_release_wdata", sram_write_data, 8'h0);

        // Test 5: locked burst, owner idles one cycle while B waits
        $display("[TB] release by idling");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0050, 8'h0);
        checkOutput("t5_c1_a_ack", a_ack, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h0);
        checkOutput("t5_c2_a_ack", a_ack, 1);
        checkOutput("t5_c2_b_ack", b_ack, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h0);
        checkOutput("t5_c3_a_ack", a_ack, 0);
        checkOutput("t5_c3_b_ack", b_ack, 0);
        checkOutput("t5_c3_select", sram_select, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h0);
        checkOutput("t5_c4_b_ack", b_ack, 1);
        checkOutput("t5_c4_a_ack", a_ack, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h0);
        checkOutput("t5_c5_a_ack", a_ack, 1);
        checkOutput("t5_c5_b_ack", b_ack, 0);
        idleCycle();

        // Test 6: reset asserted mid-burst with a read in flight
        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        checkOutput("t6_c1_a_ack", a_ack, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
        checkOutput("t6_c2_a_ack", a_ack, 1);
        checkOutput("t6_c2_a_rv", a_read_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_a_ack", a_ack, 0);
        checkOutput("t6_rst_select", sram_select, 0);
        checkOutput("t6_rst_we", sram_write_enable, 0);
        checkOutput("t6_rst_a_rv", a_read_valid, 0);
        idleCycle();
        reset_n = 1'b1;
        checkOutput("t6_after_a_rv", a_read_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 1'b0, 16'h0060, 8'h0);
        checkOutput("t6_b_ack", b_ack, 1);
        checkOutput("t6_no_stale_rv", a_read_valid, 0);
        idleCycle();
        checkOutput("t6_b_rv", b_read_valid, 1);
        checkOutput("t6_a_rv_end", a_read_valid, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
